// File: rtl/cv32e40p_tmr_checker.sv
// -----------------------------------------------------------------------------
// cv32e40p_tmr_checker
//
// Majority voter and health checker for triplicated datapath units (divider,
// multiplier). Each of NUM_CH channels carries one WIDTH-bit word from each of
// three replicas. The voted word is registered, so there is one cycle of
// latency. A replica that keeps disagreeing with the other two is retired
// after FAULT_THRESH consecutive hits. The remaining pair is then compared in
// duplex mode.
//
// Ports:
//   clk_i      in   1             clock
//   rst_ni     in   1             synchronous active-low reset
//   clear_i    in   1             clears sticky flags, error counter, streaks
//   valid_i    in   NUM_CH        per-channel replica data valid
//   rep0_i     in   NUM_CH*WIDTH  replica 0 data, channel c at [c*WIDTH +: WIDTH]
//   rep1_i     in   NUM_CH*WIDTH  replica 1 data, same packing
//   rep2_i     in   NUM_CH*WIDTH  replica 2 data, same packing
//   valid_o    out  NUM_CH        registered valid_i
//   data_o     out  NUM_CH*WIDTH  registered voted data (holds on invalid)
//   corr_o     out  NUM_CH        pulse: mismatch corrected on channel
//   uncorr_o   out  NUM_CH        pulse: mismatch not correctable on channel
//   faulty_o   out  3             sticky per-replica faulty flags
//   err_cnt_o  out  CNT_W         saturating count of corrected channel-events
//   error_o    out  1             sticky OR of any event or faulty flag
// -----------------------------------------------------------------------------
module cv32e40p_tmr_checker #(
    parameter int unsigned WIDTH        = 35,
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned FAULT_THRESH = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic [NUM_CH-1:0]       valid_i,
    input  logic [NUM_CH*WIDTH-1:0] rep0_i,
    input  logic [NUM_CH*WIDTH-1:0] rep1_i,
    input  logic [NUM_CH*WIDTH-1:0] rep2_i,
    output logic [NUM_CH-1:0]       valid_o,
    output logic [NUM_CH*WIDTH-1:0] data_o,
    output logic [NUM_CH-1:0]       corr_o,
    output logic [NUM_CH-1:0]       uncorr_o,
    output logic [2:0]              faulty_o,
    output logic [CNT_W-1:0]        err_cnt_o,
    output logic                    error_o
);

    localparam logic [CNT_W-1:0] THRESH = CNT_W'(FAULT_THRESH);

    // Saturating add used by the corrected-event counter.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [CNT_W-1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {1'b0, inc};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // Streak increment that sticks at the retirement threshold.
    function automatic logic [CNT_W-1:0] sat_streak(input logic [CNT_W-1:0] s);
        return (s >= THRESH) ? THRESH : s + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] popcnt(input logic [NUM_CH-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // Registered outputs and sticky state
    logic [NUM_CH-1:0]       vld_p1;
    logic [NUM_CH*WIDTH-1:0] data_p1;
    logic [NUM_CH-1:0]       corr_p1;
    logic [NUM_CH-1:0]       uncorr_p1;
    logic [2:0]              faulty_q;
    logic [CNT_W-1:0]        err_cnt_q;
    logic                    error_q;
    logic [CNT_W-1:0]        streak_q [3];

    // Combinational vote results
    logic [NUM_CH*WIDTH-1:0] data_d;
    logic [NUM_CH-1:0]       corr_d;
    logic [NUM_CH-1:0]       uncorr_d;
    logic [2:0]              odd_any;
    logic [2:0]              match_any;
    logic [WIDTH-1:0]        w0, w1, w2;
    logic                    eq01, eq02, eq12;
    logic                    dup_en;
    logic [WIDTH-1:0]        dup_a, dup_b;
    logic [2:0]              dup_m;

    // ---- stage p0: per-channel vote on the incoming replica words ----
    always_comb begin
        data_d    = data_p1;
        corr_d    = '0;
        uncorr_d  = '0;
        odd_any   = '0;
        match_any = '0;
        w0        = '0;
        w1        = '0;
        w2        = '0;
        eq01      = 1'b0;
        eq02      = 1'b0;
        eq12      = 1'b0;

        // With exactly one replica retired, pick the surviving pair once;
        // it is the same for every channel.
        dup_en = 1'b1;
        dup_m  = '0;
        unique case (faulty_q)
            3'b001:  dup_m = 3'b110;
            3'b010:  dup_m = 3'b101;
            3'b100:  dup_m = 3'b011;
            default: dup_en = 1'b0;
        endcase

        for (int c = 0; c < int'(NUM_CH); c++) begin
            w0   = rep0_i[c*WIDTH +: WIDTH];
            w1   = rep1_i[c*WIDTH +: WIDTH];
            w2   = rep2_i[c*WIDTH +: WIDTH];
            eq01 = (w0 == w1);
            eq02 = (w0 == w2);
            eq12 = (w1 == w2);
            dup_a = dup_m[0] ? w0 : w1;
            dup_b = dup_m[2] ? w2 : w1;

            if (valid_i[c]) begin
                if (faulty_q == 3'b000) begin
                    if (eq01 && eq12) begin
                        data_d[c*WIDTH +: WIDTH] = w0;
                        match_any = 3'b111;
                    end else if (eq01) begin
                        data_d[c*WIDTH +: WIDTH] = w0;
                        corr_d[c]  = 1'b1;
                        odd_any    = odd_any | 3'b100;
                        match_any  = match_any | 3'b011;
                    end else if (eq02) begin
                        data_d[c*WIDTH +: WIDTH] = w0;
                        corr_d[c]  = 1'b1;
                        odd_any    = odd_any | 3'b010;
                        match_any  = match_any | 3'b101;
                    end else if (eq12) begin
                        data_d[c*WIDTH +: WIDTH] = w1;
                        corr_d[c]  = 1'b1;
                        odd_any    = odd_any | 3'b001;
                        match_any  = match_any | 3'b110;
                    end else begin
                        // No majority: keep last good word, flag it.
                        uncorr_d[c] = 1'b1;
                    end
                end else if (dup_en) begin
                    if (dup_a == dup_b) begin
                        data_d[c*WIDTH +: WIDTH] = dup_a;
                        match_any = match_any | dup_m;
                    end else begin
                        uncorr_d[c] = 1'b1;
                    end
                end else begin
                    // Two or more retired: pass the first survivor through,
                    // nothing left to vote against. All retired: hold.
                    uncorr_d[c] = 1'b1;
                    if (!faulty_q[0]) begin
                        data_d[c*WIDTH +: WIDTH] = w0;
                    end else if (!faulty_q[1]) begin
                        data_d[c*WIDTH +: WIDTH] = w1;
                    end else if (!faulty_q[2]) begin
                        data_d[c*WIDTH +: WIDTH] = w2;
                    end
                end
            end
        end
    end

    // Streak and sticky-state next values
    logic [CNT_W-1:0] streak_d [3];
    logic [2:0]       faulty_set;
    logic [2:0]       faulty_d;
    logic [CNT_W-1:0] err_cnt_d;
    logic             error_d;

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            faulty_set[r] = !faulty_q[r] && (streak_q[r] == THRESH);
            streak_d[r]   = streak_q[r];
            if (clear_i) begin
                streak_d[r] = '0;
            end else if (!faulty_q[r]) begin
                // Being outvoted anywhere outweighs agreeing elsewhere.
                if (odd_any[r]) begin
                    streak_d[r] = sat_streak(streak_q[r]);
                end else if (match_any[r]) begin
                    streak_d[r] = '0;
                end
            end
        end

        if (clear_i) begin
            faulty_d  = '0;
            err_cnt_d = '0;
            error_d   = 1'b0;
        end else begin
            faulty_d  = faulty_q | faulty_set;
            err_cnt_d = sat_add(err_cnt_q, popcnt(corr_d));
            error_d   = error_q | (|corr_d) | (|uncorr_d) | (|faulty_set);
        end
    end

    // ---- stage p1: registered vote result and sticky status ----
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_p1    <= '0;
            data_p1   <= '0;
            corr_p1   <= '0;
            uncorr_p1 <= '0;
            faulty_q  <= '0;
            err_cnt_q <= '0;
            error_q   <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                streak_q[r] <= '0;
            end
        end else begin
            vld_p1    <= valid_i;
            data_p1   <= data_d;
            corr_p1   <= corr_d;
            uncorr_p1 <= uncorr_d;
            faulty_q  <= faulty_d;
            err_cnt_q <= err_cnt_d;
            error_q   <= error_d;
            for (int r = 0; r < 3; r++) begin
                streak_q[r] <= streak_d[r];
            end
        end
    end

    assign valid_o   = vld_p1;
    assign data_o    = data_p1;
    assign corr_o    = corr_p1;
    assign uncorr_o  = uncorr_p1;
    assign faulty_o  = faulty_q;
    assign err_cnt_o = err_cnt_q;
    assign error_o   = error_q;

endmodule

// File: doc/cv32e40p_tmr_checker.md
Name: cv32e40p_tmr_checker

Overview:
- Parametrised TMR voter/checker for triplicated datapath units (divider, multiplier) in cv32e40p_core.
- Successor to the fixed per-unit TMR taps: NUM_CH channels of WIDTH bits, word-wise majority voting, registered voted result.
- Tracks consecutive mismatches per replica, retires a replica as faulty after FAULT_THRESH hits, then degrades to duplex compare.
- Drives sticky and pulsed error status toward the core error output (cs_error).

Parameters:
- WIDTH, 35, bits per channel per replica.
- NUM_CH, 2, independent voted channels.
- FAULT_THRESH, 4, consecutive odd-one-out cycles before a replica is marked faulty; range 1..2^CNT_W-1.
- CNT_W, 8, width of the saturating correctable-error counter and the per-replica streak counters.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- clear_i  in  1  clears sticky state and counters.
- valid_i  in  NUM_CH  per-channel replica data valid.
- rep0_i  in  NUM_CH*WIDTH  replica 0 data; channel c occupies bits [c*WIDTH +: WIDTH].
- rep1_i  in  NUM_CH*WIDTH  replica 1 data, same packing.
- rep2_i  in  NUM_CH*WIDTH  replica 2 data, same packing.
- valid_o  out  NUM_CH  registered valid_i.
- data_o  out  NUM_CH*WIDTH  registered voted data.
- corr_o  out  NUM_CH  pulse: mismatch on the channel was corrected.
- uncorr_o  out  NUM_CH  pulse: mismatch on the channel could not be corrected.
- faulty_o  out  3  sticky per-replica faulty flags.
- err_cnt_o  out  CNT_W  saturating count of corrected channel-events.
- error_o  out  1  sticky OR of any corr/uncorr event or faulty flag.

Behaviour:
- Reset (rst_ni=0 at a clk_i edge): all outputs 0, streak counters 0.
- Latency: 1 cycle. valid_o, data_o, corr_o and uncorr_o are registered from the cycle-N inputs.
- data_o is updated only for channels with valid_i=1; it holds otherwise.
- Voting, per valid channel, no replica faulty:
  - a==b==c: output a, no event.
  - exactly two equal: output the majority word; corr=1; the minority replica is the odd-one-out.
  - all three differ: output the previous data_o for that channel (held); uncorr=1.
- Voting, per valid channel, exactly one replica faulty: compare the two healthy replicas.
  - Equal: output that value, no event.
  - Different: hold data_o; uncorr=1.
- Voting, per valid channel, two or more replicas faulty: output the lowest-index healthy replica; uncorr=1 every valid cycle.
- Streak counters, one per replica, per cycle:
  - +1 if the replica is the odd-one-out on any valid channel.
  - Reset to 0 if it matched the majority on any valid channel and was not the odd-one-out on any channel.
  - Hold if no channel is valid or no majority exists.
  - Saturate at FAULT_THRESH.
- Faulty flag: when a streak counter reaches FAULT_THRESH, faulty_o[r] is set on the next edge and stays set until clear_i or reset. Faulty replicas stop counting.
- err_cnt_o: increments by popcount(corr) each cycle and saturates at all-ones.
- error_o: set on the edge after any corr, uncorr or faulty event.
- clear_i=1: on the next edge, faulty_o, err_cnt_o, error_o and streak counters go to 0.
  - Events in the same cycle do not update sticky state or counters.
  - Voting, data_o, valid_o and pulses still behave normally that cycle.
- Channels are evaluated independently; sticky state is shared.

Test Plan:
- Reset, then all replicas = 0x1234 on ch0 with valid=01 -> next cycle data_o[ch0]=0x1234, corr=0, uncorr=0, error_o=0.
- ch1: rep0=5, rep1=5, rep2=7, valid=10 -> data_o[ch1]=5, corr=10, err_cnt=1, error_o=1, rep2 streak=1.
- rep2 odd-one-out for 4 consecutive valid cycles (FAULT_THRESH=4) -> faulty_o=100. Then rep0=1, rep1=2 -> uncorr=1, data_o held.
- All three differ on ch0 (1,2,3) with previous data_o=9 -> data_o stays 9, uncorr=01, err_cnt unchanged.
- err_cnt at 0xFF, further corrected events -> stays 0xFF. Then clear_i=1 together with a mismatch -> all sticky state and counters read 0 the next cycle, corr pulse still asserted.
- rst_ni low mid-streak (rep1 streak=3) -> all outputs 0. A subsequent single rep1 mismatch does not set faulty_o.
